// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter sharing one synchronous data BRAM between CPU and VGA fetch.
// Optional stall statistics counter enabled by defining DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
   parameter int ADDR_W         = 14,
   parameter int DATA_W         = 32,
   parameter int VGA_MAX_STREAK = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic              vga_gnt,
   output logic              vga_rvalid,
   output logic [DATA_W-1:0] vga_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [15:0]       stall_cnt
);

   localparam logic [3:0] MAX_STREAK = 4'(VGA_MAX_STREAK);

   logic [3:0]        streak_q, streak_d;
   logic              at_max;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic              vga_rvalid_q, vga_rvalid_d;
   logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
   logic [DATA_W-1:0] vga_hold_q, vga_hold_d;

   // VGA wins contention until the CPU has waited out a full streak
   always_comb begin
      at_max  = (streak_q >= MAX_STREAK);
      cpu_gnt = ~rst & cpu_req & (~vga_req | at_max);
      vga_gnt = ~rst & vga_req & ~(cpu_req & at_max);
   end

   always_comb begin
      streak_d = streak_q;
      if (rst || cpu_gnt || !cpu_req)
         streak_d = '0;
      else if (vga_gnt)
         streak_d = streak_q + 4'd1;
   end

   always_comb begin
      mem_en    = cpu_gnt | vga_gnt;
      mem_we    = cpu_gnt & cpu_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (vga_gnt) begin
         mem_addr  = vga_addr;
      end
   end

   always_comb begin
      cpu_rvalid_d = cpu_gnt & ~cpu_we;
      vga_rvalid_d = vga_gnt;
      cpu_hold_d   = cpu_hold_q;
      vga_hold_d   = vga_hold_q;
      if (rst) begin
         cpu_hold_d = '0;
         vga_hold_d = '0;
      end else begin
         if (cpu_rvalid_q) cpu_hold_d = mem_rdata;
         if (vga_rvalid_q) vga_hold_d = mem_rdata;
      end
   end

   // Reset masks the in-flight response so nothing leaks out during rst
   always_comb begin
      cpu_rvalid = cpu_rvalid_q & ~rst;
      vga_rvalid = vga_rvalid_q & ~rst;
      cpu_rdata  = '0;
      vga_rdata  = '0;
      if (!rst) begin
         cpu_rdata = cpu_rvalid_q ? mem_rdata : cpu_hold_q;
         vga_rdata = vga_rvalid_q ? mem_rdata : vga_hold_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         streak_q     <= '0;
         cpu_rvalid_q <= 1'b0;
         vga_rvalid_q <= 1'b0;
         cpu_hold_q   <= '0;
         vga_hold_q   <= '0;
      end else begin
         streak_q     <= streak_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         vga_rvalid_q <= vga_rvalid_d;
         cpu_hold_q   <= cpu_hold_d;
         vga_hold_q   <= vga_hold_d;
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (cpu_req && !cpu_gnt && !(&stall_q))
         stall_d = stall_q + 16'd1;
      stall_cnt = rst ? 16'd0 : stall_q;
   end

   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end
`else
   assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed table-driven bench for dmem_port_arbiter with a behavioural BRAM.
module tb_dmem_port_arbiter;

   localparam int AW = 14;
   localparam int DW = 32;
`ifdef DMEM_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt, cpu_rvalid;
   logic [DW-1:0] cpu_rdata;
   logic          vga_req;
   logic [AW-1:0] vga_addr;
   logic          vga_gnt, vga_rvalid;
   logic [DW-1:0] vga_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [15:0]   stall_cnt;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .VGA_MAX_STREAK(3)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .cpu_rdata(cpu_rdata), .vga_req(vga_req), .vga_addr(vga_addr),
      .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
   );

   logic [DW-1:0] ram [0:(1<<AW)-1];

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return {16'hA5A5, 2'b00, a};
   endfunction

   initial begin
      for (int i = 0; i < (1 << AW); i++) ram[i] = pat(AW'(i));
      mem_rdata = '0;
   end

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   typedef struct {
      logic          r, cq, cw;
      logic [AW-1:0] ca;
      logic [DW-1:0] cd;
      logic          vq;
      logic [AW-1:0] va;
      logic          gc, gv, we;
      logic [AW-1:0] ma;
      logic          crv;
      logic [DW-1:0] crd;
      logic          vrv;
      logic [DW-1:0] vrd;
      logic [15:0]   st;
   } vec_t;

   vec_t v [$];

   function automatic vec_t mk(
      input logic r, cq, cw, input logic [AW-1:0] ca,
      input logic [DW-1:0] cd, input logic vq, input logic [AW-1:0] va,
      input logic gc, gv, we, input logic [AW-1:0] ma,
      input logic crv, input logic [DW-1:0] crd,
      input logic vrv, input logic [DW-1:0] vrd, input logic [15:0] st);
      vec_t t;
      t.r = r; t.cq = cq; t.cw = cw; t.ca = ca; t.cd = cd;
      t.vq = vq; t.va = va; t.gc = gc; t.gv = gv; t.we = we;
      t.ma = ma; t.crv = crv; t.crd = crd; t.vrv = vrv; t.vrd = vrd;
      t.st = STATS ? st : 16'd0;
      return t;
   endfunction

   task automatic chk(input string nm, input int idx,
                      input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rst = t.r; cpu_req = t.cq; cpu_we = t.cw; cpu_addr = t.ca;
      cpu_wdata = t.cd; vga_req = t.vq; vga_addr = t.va;
   endtask

   initial begin
      logic [DW-1:0] dbe;
      logic [DW-1:0] w2;
      dbe = 32'hDEADBEEF;
      w2  = 32'h12345678;
      // rst cq cw ca cd vq va | gc gv we ma crv crd vrv vrd st
      v.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0));
      v.push_back(mk(0,1,1,14'h10,dbe,0,0, 1,0,1,14'h10, 0,0,0,0,0));
      v.push_back(mk(0,1,0,14'h10,0,0,0, 1,0,0,14'h10, 0,0,0,0,0));
      v.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 1,dbe,0,0,0));
      v.push_back(mk(0,0,0,0,0,1,14'h100, 0,1,0,14'h100, 0,dbe,0,0,0));
      v.push_back(mk(0,0,0,0,0,1,14'h101, 0,1,0,14'h101,
                     0,dbe,1,pat(14'h100),0));
      v.push_back(mk(0,0,0,0,0,1,14'h102, 0,1,0,14'h102,
                     0,dbe,1,pat(14'h101),0));
      v.push_back(mk(0,0,0,0,0,1,14'h103, 0,1,0,14'h103,
                     0,dbe,1,pat(14'h102),0));
      v.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0,dbe,1,pat(14'h103),0));
      v.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 0,dbe,0,pat(14'h103),0));
      // contention V,V,V,C,V,V,V,C
      v.push_back(mk(0,1,0,14'h20,0,1,14'h200, 0,1,0,14'h200,
                     0,dbe,0,pat(14'h103),0));
      v.push_back(mk(0,1,0,14'h20,0,1,14'h200, 0,1,0,14'h200,
                     0,dbe,1,pat(14'h200),1));
      v.push_back(mk(0,1,0,14'h20,0,1,14'h200, 0,1,0,14'h200,
                     0,dbe,1,pat(14'h200),2));
      v.push_back(mk(0,1,0,14'h20,0,1,14'h200, 1,0,0,14'h20,
                     0,dbe,1,pat(14'h200),3));
      v.push_back(mk(0,1,0,14'h20,0,1,14'h200, 0,1,0,14'h200,
                     1,pat(14'h20),0,pat(14'h200),3));
      v.push_back(mk(0,1,0,14'h20,0,1,14'h200, 0,1,0,14'h200,
                     0,pat(14'h20),1,pat(14'h200),4));
      v.push_back(mk(0,1,0,14'h20,0,1,14'h200, 0,1,0,14'h200,
                     0,pat(14'h20),1,pat(14'h200),5));
      v.push_back(mk(0,1,0,14'h20,0,1,14'h200, 1,0,0,14'h20,
                     0,pat(14'h20),1,pat(14'h200),6));
      v.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,
                     1,pat(14'h20),0,pat(14'h200),6));
      // reset in the cycle after a CPU read grant
      v.push_back(mk(0,1,0,14'h30,0,0,0, 1,0,0,14'h30,
                     0,pat(14'h20),0,pat(14'h200),6));
      v.push_back(mk(1,1,0,14'h30,0,1,14'h300, 0,0,0,0, 0,0,0,0,0));
      // CPU write colliding with VGA at the streak limit
      v.push_back(mk(0,1,1,14'h40,w2,1,14'h300, 0,1,0,14'h300, 0,0,0,0,0));
      v.push_back(mk(0,1,1,14'h40,w2,1,14'h300, 0,1,0,14'h300,
                     0,0,1,pat(14'h300),1));
      v.push_back(mk(0,1,1,14'h40,w2,1,14'h300, 0,1,0,14'h300,
                     0,0,1,pat(14'h300),2));
      v.push_back(mk(0,1,1,14'h40,w2,1,14'h300, 1,0,1,14'h40,
                     0,0,1,pat(14'h300),3));
      v.push_back(mk(0,0,0,0,0,1,14'h300, 0,1,0,14'h300,
                     0,0,0,pat(14'h300),3));
      v.push_back(mk(0,1,0,14'h40,0,0,0, 1,0,0,14'h40,
                     0,0,1,pat(14'h300),3));
      v.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0, 1,w2,0,pat(14'h300),3));

      drive(v[0]);
      repeat (2) @(negedge clk);
      foreach (v[i]) begin
         @(negedge clk);
         drive(v[i]);
         #1;
         chk("cpu_gnt", i, DW'(cpu_gnt), DW'(v[i].gc));
         chk("vga_gnt", i, DW'(vga_gnt), DW'(v[i].gv));
         chk("mem_en", i, DW'(mem_en), DW'(v[i].gc | v[i].gv));
         chk("mem_we", i, DW'(mem_we), DW'(v[i].we));
         chk("mem_addr", i, DW'(mem_addr), DW'(v[i].ma));
         chk("cpu_rvalid", i, DW'(cpu_rvalid), DW'(v[i].crv));
         chk("cpu_rdata", i, cpu_rdata, v[i].crd);
         chk("vga_rvalid", i, DW'(vga_rvalid), DW'(v[i].vrv));
         chk("vga_rdata", i, vga_rdata, v[i].vrd);
         chk("stall_cnt", i, DW'(stall_cnt), DW'(v[i].st));
      end

      // back-to-back CPU writes then a read: write data routing and throughput
      @(negedge clk);
      rst = 0; vga_req = 0; cpu_req = 1; cpu_we = 1;
      cpu_addr = 14'h50; cpu_wdata = 32'hCAFE0001;
      #1;
      chk("b2b_wdata", 0, mem_wdata, 32'hCAFE0001);
      chk("b2b_gnt", 0, DW'(cpu_gnt), 32'd1);
      @(negedge clk);
      cpu_addr = 14'h51; cpu_wdata = 32'hCAFE0002;
      #1;
      chk("b2b_wdata", 1, mem_wdata, 32'hCAFE0002);
      chk("b2b_we", 1, DW'(mem_we), 32'd1);
      @(negedge clk);
      cpu_we = 0; cpu_addr = 14'h51; cpu_wdata = 32'h0;
      #1;
      chk("b2b_rd_wdata", 2, mem_wdata, 32'h0);
      chk("b2b_rd_we", 2, DW'(mem_we), 32'd0);
      @(negedge clk);
      cpu_req = 0; cpu_addr = '0;
      #1;
      chk("b2b_rvalid", 3, DW'(cpu_rvalid), 32'd1);
      chk("b2b_rdata", 3, cpu_rdata, 32'hCAFE0002);
      chk("idle_addr", 3, DW'(mem_addr), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
